bus_master: RTL and testbench
=============================

BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the number of WAIT cycles without ack before an error response; legal range is 2..255.
REQ-002 bus_clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 bus_reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 i_req_valid  in  1  SHALL mean the core presents a request.
REQ-005 o_req_ready  out  1  SHALL mean the request is accepted on this edge when i_req_valid=1.
REQ-006 i_req_we  in  1  SHALL select write (1) or read (0).
REQ-007 i_req_addr  in  16  SHALL be the request word address.
REQ-008 i_req_wdata  in  16  SHALL be the write data.
REQ-009 o_rsp_valid  out  1  SHALL mean a response is held.
REQ-010 i_rsp_ready  in  1  SHALL mean the core consumes the response this edge.
REQ-011 o_rsp_rdata  out  16  SHALL be read data; 0 for writes and errors.
REQ-012 o_rsp_err  out  1  SHALL flag a timeout response.
REQ-013 o_bus_addr, o_bus_data_write  out  16 each  SHALL drive the bus controller address and write data.
REQ-014 o_bus_we, o_bus_re  out  1 each  SHALL be the one-cycle write/read strobes; never both 1.
REQ-015 i_bus_data_read  in  16, i_bus_ack  in  1, i_bus_ready  in  1  SHALL be the bus controller read data, completion flag (level, sticky high until next request) and idle indication.

Function
REQ-016 States SHALL be IDLE, STROBE, WAIT, RESP; all outputs registered except o_req_ready.
REQ-017 o_req_ready SHALL equal (state==IDLE) && i_bus_ready; only one transaction outstanding.
REQ-018 On acceptance the block SHALL latch addr/wdata/we into o_bus_*, raise exactly one strobe (o_bus_we if write, else o_bus_re) and enter STROBE.
REQ-019 STROBE SHALL last exactly one cycle: strobes drop to 0, WAIT counter cleared to 0, enter WAIT; i_bus_ack SHALL be ignored in STROBE (stale ack from previous transaction).
REQ-020 In WAIT, i_bus_ack=1 SHALL capture o_rsp_rdata = write ? 0 : i_bus_data_read, o_rsp_err=0, o_rsp_valid=1, enter RESP.
REQ-021 In WAIT without ack the counter SHALL increment; when it reaches TIMEOUT_CYCLES-1 the block SHALL respond with o_rsp_err=1, o_rsp_rdata=0, enter RESP; ack and timeout on the same edge SHALL resolve as ack.
REQ-022 In RESP, o_rsp_valid/rdata/err SHALL hold until i_rsp_ready=1, then o_rsp_valid<=0 and state<=IDLE.
REQ-023 After a timeout no new request SHALL issue until i_bus_ready=1 (REQ-017 guarantees this).
REQ-024 o_bus_addr/o_bus_data_write SHALL hold their last value outside STROBE; the bad-address ack from the controller (data 0) SHALL be reported as a normal, non-error response.
REQ-025 Against the bus controller (wait count 1), o_rsp_valid SHALL rise on the 4th edge after acceptance.

Reset
REQ-026 While bus_reset_n=0: state=IDLE, o_bus_we=o_bus_re=0, o_bus_addr=o_bus_data_write=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, WAIT counter=0.
REQ-027 Reset asserted mid-transaction SHALL abort it with no response; after release, issue SHALL wait for i_bus_ready=1.

Structure
REQ-028 State encoding, address-map constants (RAM 0000-BEFF, IO BF00-BFFF, VGA BF00-BF01, VRAM C000-FFFF) and TIMEOUT default SHALL live in shared package bus_pkg.
REQ-029 The WAIT counter MAY be sub-module bus_timeout (clear, enable, terminal-count out); otherwise flat.

Verification
REQ-030 Read 0x0010 against bus_ctrl+RAM holding 0xBEEF -> one-cycle o_bus_re, o_rsp_valid on 4th edge, rdata 0xBEEF, err 0.
REQ-031 Write 0xC005=0x1234 then read 0xC005 -> o_bus_we one cycle, write rsp rdata 0; read returns 0x1234; second issue waits for i_bus_ready.
REQ-032 Read 0xBF10 (bad address) -> rsp rdata 0x0000, err 0.
REQ-033 Ack held low (stub), TIMEOUT_CYCLES=16 -> rsp err 1 after 16 WAIT cycles, rdata 0.
REQ-034 i_rsp_ready low for 5 cycles -> rsp held stable, o_req_ready 0 throughout.
REQ-035 Reset pulsed during WAIT -> all outputs per REQ-026, no response emitted, next read completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_pkg
// Brief   : Shared bus master state encoding, address map and timeout default.
// Revision: 1.0 - initial release
// ============================================================================
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int TIMER_W         = 8;

  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [15:0] RAM_LAST  = 16'hBEFF;
  localparam logic [15:0] IO_BASE   = 16'hBF00;
  localparam logic [15:0] IO_LAST   = 16'hBFFF;
  localparam logic [15:0] VGA_BASE  = 16'hBF00;
  localparam logic [15:0] VGA_LAST  = 16'hBF01;
  localparam logic [15:0] VRAM_BASE = 16'hC000;
  localparam logic [15:0] VRAM_LAST = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/bus_timeout.sv
`default_nettype none
// ============================================================================
// Module  : bus_timeout
// Brief   : WAIT-cycle counter; done flags the last permitted cycle without ack.
// Revision: 1.0 - initial release
// ============================================================================
module bus_timeout
  import bus_pkg::*;
#(
  parameter int TERMINAL = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign done = (count == TIMER_W'(TERMINAL - 1));

endmodule
`default_nettype wire

// File: rtl/bus_master.sv
`default_nettype none
// ============================================================================
// Module  : bus_master
// Brief   : Single-outstanding request/response master for the bus controller.
// Revision: 1.0 - initial release
// ============================================================================
module bus_master
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        bus_clock,
  input  logic        bus_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [15:0] i_req_addr,
  input  logic [15:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [15:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [15:0] o_bus_addr,
  output logic [15:0] o_bus_data_write,
  output logic        o_bus_we,
  output logic        o_bus_re,
  input  logic [15:0] i_bus_data_read,
  input  logic        i_bus_ack,
  input  logic        i_bus_ready
);

  state_t      state, state_nxt;
  logic        is_write, is_write_nxt;
  logic [15:0] addr_nxt, wdata_nxt, rdata_nxt;
  logic        we_nxt, re_nxt, rsp_valid_nxt, err_nxt;
  logic        cnt_clear, cnt_en, cnt_done;

  bus_timeout #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (bus_clock),
    .rst_n  (bus_reset_n),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .done   (cnt_done)
  );

  assign o_req_ready = (state == ST_IDLE) && i_bus_ready;

  always_comb begin
    state_nxt     = state;
    is_write_nxt  = is_write;
    addr_nxt      = o_bus_addr;
    wdata_nxt     = o_bus_data_write;
    we_nxt        = 1'b0;
    re_nxt        = 1'b0;
    rsp_valid_nxt = o_rsp_valid;
    rdata_nxt     = o_rsp_rdata;
    err_nxt       = o_rsp_err;
    cnt_clear     = 1'b0;
    cnt_en        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req_valid && o_req_ready) begin
          addr_nxt     = i_req_addr;
          wdata_nxt    = i_req_wdata;
          is_write_nxt = i_req_we;
          we_nxt       = i_req_we;
          re_nxt       = !i_req_we;
          state_nxt    = ST_STROBE;
        end
      end
      // Ack seen here is left over from the previous transaction.
      ST_STROBE: begin
        cnt_clear = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_bus_ack) begin
          rdata_nxt     = is_write ? 16'h0000 : i_bus_data_read;
          err_nxt       = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = ST_RESP;
        end else if (cnt_done) begin
          rdata_nxt     = 16'h0000;
          err_nxt       = 1'b1;
          rsp_valid_nxt = 1'b1;
          state_nxt     = ST_RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge bus_clock or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      state            <= ST_IDLE;
      is_write         <= 1'b0;
      o_bus_addr       <= 16'h0000;
      o_bus_data_write <= 16'h0000;
      o_bus_we         <= 1'b0;
      o_bus_re         <= 1'b0;
      o_rsp_valid      <= 1'b0;
      o_rsp_rdata      <= 16'h0000;
      o_rsp_err        <= 1'b0;
    end else begin
      state            <= state_nxt;
      is_write         <= is_write_nxt;
      o_bus_addr       <= addr_nxt;
      o_bus_data_write <= wdata_nxt;
      o_bus_we         <= we_nxt;
      o_bus_re         <= re_nxt;
      o_rsp_valid      <= rsp_valid_nxt;
      o_rsp_rdata      <= rdata_nxt;
      o_rsp_err        <= err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_master
// Brief   : Self-checking bench for bus_master with a behavioural bus controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_master;

  logic        bus_clock = 1'b0;
  logic        rst_n     = 1'b1;
  logic        req_valid, req_we, rsp_ready;
  logic [15:0] req_addr, req_wdata;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_bus_we, o_bus_re;
  logic [15:0] o_rsp_rdata, o_bus_addr, o_bus_data_write;

  logic        bus_ack       = 1'b0;
  logic [15:0] bus_data_read = 16'h0000;
  logic        ctrl_ready    = 1'b1;
  logic        bus_ready;
  logic        hold_busy     = 1'b0;
  logic        stub_mode     = 1'b0;
  logic        busy          = 1'b0;
  logic [15:0] rd_buf        = 16'h0000;
  int          wcnt          = 0;
  int          wait_cnt      = 1;
  logic [15:0] ctrl_mem [0:65535];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  vec_t vec [13];
  exp_t sb [$];
  logic prev_strobe = 1'b0;

  always #5 bus_clock = ~bus_clock;

  assign bus_ready = ctrl_ready && !hold_busy;

  bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .bus_clock        (bus_clock),
    .bus_reset_n      (rst_n),
    .i_req_valid      (req_valid),
    .o_req_ready      (o_req_ready),
    .i_req_we         (req_we),
    .i_req_addr       (req_addr),
    .i_req_wdata      (req_wdata),
    .o_rsp_valid      (o_rsp_valid),
    .i_rsp_ready      (rsp_ready),
    .o_rsp_rdata      (o_rsp_rdata),
    .o_rsp_err        (o_rsp_err),
    .o_bus_addr       (o_bus_addr),
    .o_bus_data_write (o_bus_data_write),
    .o_bus_we         (o_bus_we),
    .o_bus_re         (o_bus_re),
    .i_bus_data_read  (bus_data_read),
    .i_bus_ack        (bus_ack),
    .i_bus_ready      (bus_ready)
  );

  function automatic logic addr_ok(input logic [15:0] a);
    return (a <= 16'hBEFF) || (a >= 16'hC000) || (a <= 16'hBF01);
  endfunction

  // Controller: one wait cycle by default, ack is a sticky level until the next strobe.
  always @(posedge bus_clock) begin
    if (o_bus_we || o_bus_re) begin
      bus_ack    <= 1'b0;
      ctrl_ready <= 1'b0;
      busy       <= 1'b1;
      wcnt       <= wait_cnt;
      if (o_bus_we) begin
        if (addr_ok(o_bus_addr)) ctrl_mem[o_bus_addr] <= o_bus_data_write;
        rd_buf <= 16'hDEAD;
      end else begin
        rd_buf <= addr_ok(o_bus_addr) ? ctrl_mem[o_bus_addr] : 16'h0000;
      end
    end else if (busy) begin
      if (wcnt != 0) begin
        wcnt <= wcnt - 1;
      end else begin
        busy       <= 1'b0;
        ctrl_ready <= 1'b1;
        if (!stub_mode) begin
          bus_ack       <= 1'b1;
          bus_data_read <= rd_buf;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [15:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge bus_clock);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    while (!o_req_ready && n < 200) begin
      @(negedge bus_clock);
      n++;
    end
    if (!o_req_ready) begin
      chk("issue_accept", 64'(o_req_ready), 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge bus_clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge bus_clock);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_pending", 64'(sb.size()), 0);
      sb.delete();
    end
  endtask

  // Response scoreboard and strobe monitor.
  always begin
    @(negedge bus_clock);
    #1;
    if (o_bus_we || o_bus_re) begin
      chk("strobe_exclusive", 64'(o_bus_we & o_bus_re), 0);
      chk("strobe_width", 64'(prev_strobe), 0);
    end
    prev_strobe = o_bus_we | o_bus_re;
    if (o_rsp_valid && rsp_ready) begin
      chk("rsp_pending", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", 64'(o_rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(o_rsp_err), 64'(e.err));
      end
    end
  end

  initial begin
    int first;
    int re_cnt;
    int we_cnt;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    ctrl_mem[16'h0010] = 16'hBEEF;
    ctrl_mem[16'hFFFF] = 16'h5A5A;

    vec[0]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    vec[1]  = '{1'b1, 16'hC005, 16'h1234, 16'h0000, 1'b0};
    vec[2]  = '{1'b0, 16'hC005, 16'h0000, 16'h1234, 1'b0};
    vec[3]  = '{1'b0, 16'hBF10, 16'h0000, 16'h0000, 1'b0};
    vec[4]  = '{1'b1, 16'h0100, 16'hA5A5, 16'h0000, 1'b0};
    vec[5]  = '{1'b0, 16'h0100, 16'h0000, 16'hA5A5, 1'b0};
    vec[6]  = '{1'b1, 16'hBF00, 16'h0042, 16'h0000, 1'b0};
    vec[7]  = '{1'b0, 16'hBF00, 16'h0000, 16'h0042, 1'b0};
    vec[8]  = '{1'b1, 16'hBF20, 16'h7777, 16'h0000, 1'b0};
    vec[9]  = '{1'b0, 16'hBF20, 16'h0000, 16'h0000, 1'b0};
    vec[10] = '{1'b0, 16'hFFFF, 16'h0000, 16'h5A5A, 1'b0};
    vec[11] = '{1'b1, 16'hBEFF, 16'hFFFF, 16'h0000, 1'b0};
    vec[12] = '{1'b0, 16'hBEFF, 16'h0000, 16'hFFFF, 1'b0};

    #1 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {12'h0, o_rsp_valid, o_rsp_err, o_bus_we, o_bus_re,
                          o_rsp_rdata, o_bus_addr, o_bus_data_write}, 0);
    chk("reset_req_ready", 64'(o_req_ready), 1);
    repeat (3) @(negedge bus_clock);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      sb_push(vec[i].exp_rdata, vec[i].exp_err);
      issue(vec[i].we, vec[i].addr, vec[i].wdata);
    end
    drain();

    // Latency: strobe on the first edge, response on the 4th edge after acceptance.
    sb_push(16'hBEEF, 1'b0);
    issue(1'b0, 16'h0010, 16'h0000);
    first = -1; re_cnt = 0; we_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge bus_clock);
      if (k == 1) chk("lat_bus_addr", 64'(o_bus_addr), 64'h0010);
      re_cnt += int'(o_bus_re);
      we_cnt += int'(o_bus_we);
      if (o_rsp_valid && first < 0) first = k - 1;
    end
    chk("lat_edges", 64'(first), 4);
    chk("lat_re_pulses", 64'(re_cnt), 1);
    chk("lat_we_pulses", 64'(we_cnt), 0);
    drain();

    // Backpressure: response held stable, no new acceptance.
    rsp_ready = 1'b0;
    sb_push(16'hBEEF, 1'b0);
    issue(1'b0, 16'h0010, 16'h0000);
    first = 0;
    while (!o_rsp_valid && first < 20) begin
      @(negedge bus_clock);
      first++;
    end
    chk("bp_rsp_seen", 64'(o_rsp_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge bus_clock);
      chk("bp_valid", 64'(o_rsp_valid), 1);
      chk("bp_rdata", 64'(o_rsp_rdata), 64'hBEEF);
      chk("bp_req_ready", 64'(o_req_ready), 0);
    end
    rsp_ready = 1'b1;
    drain();

    // Timeout: 1 STROBE edge + 16 WAIT edges, then held off until bus ready.
    stub_mode = 1'b1;
    sb_push(16'h0000, 1'b1);
    issue(1'b0, 16'h0010, 16'h0000);
    hold_busy = 1'b1;
    first = -1;
    for (int k = 1; k <= 30 && first < 0; k++) begin
      @(negedge bus_clock);
      if (o_rsp_valid) first = k - 1;
    end
    chk("to_edges", 64'(first), 17);
    drain();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge bus_clock);
      chk("to_req_blocked", 64'(o_req_ready), 0);
    end
    req_valid = 1'b0;
    hold_busy = 1'b0;
    stub_mode = 1'b0;
    sb_push(16'hBEEF, 1'b0);
    issue(1'b0, 16'h0010, 16'h0000);
    drain();

    // Reset during WAIT aborts silently; next read ignores the stale ack.
    wait_cnt = 6;
    issue(1'b0, 16'hC005, 16'h0000);
    repeat (3) @(negedge bus_clock);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {12'h0, o_rsp_valid, o_rsp_err, o_bus_we, o_bus_re,
                            o_rsp_rdata, o_bus_addr, o_bus_data_write}, 0);
    repeat (2) @(negedge bus_clock);
    rst_n = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
    #1;
    chk("rst_wait_bus_ready", 64'(o_req_ready), 0);
    req_valid = 1'b0;
    wait_cnt = 1;
    sb_push(16'hBEEF, 1'b0);
    issue(1'b0, 16'h0010, 16'h0000);
    drain();
    repeat (4) @(negedge bus_clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
